// File: rtl/sdram_port_arbiter.sv
// Purpose : shares one 8-bit SDRAM core port between the ROM loader (writes) and two
//           video read clients (c0 = BG tile fetch, c1 = sprite fetch) with req/ack.
// Latency : req seen in IDLE cycle N -> mem strobe at N+1; mem_ack at M -> client ack at M+1.
// Backpr. : one access in flight; other requesters hold their level req until acked.
//
// Ports (clk_sys domain, synchronous active-high reset):
//   ldr_active            download in progress, blocks read grants
//   ldr_req/addr/data/ack loader write channel (ack = 1-cycle pulse)
//   cN_req/addr/data/ack  read clients 0/1 (data held until the client's next read)
//   mem_addr/din/rd/we    registered command to the sdram core (rd/we 1-cycle strobes)
//   mem_dout/mem_ack      completion from the sdram core
//   busy                  FSM not in IDLE
//   err                   sticky watchdog error
//
// Optional feature: define ARB_TIMEOUT_EN to enable the WAIT watchdog (limit TIMEOUT
// cycles). Without it WAIT blocks until mem_ack and err is tied low.
module sdram_port_arbiter #(
  parameter int AW      = 25,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ldr_active,
  input  logic          ldr_req,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_data,
  output logic          ldr_ack,
  input  logic          c0_req,
  input  logic [AW-1:0] c0_addr,
  output logic [DW-1:0] c0_data,
  output logic          c0_ack,
  input  logic          c1_req,
  input  logic [AW-1:0] c1_addr,
  output logic [DW-1:0] c1_data,
  output logic          c1_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_rd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_ack,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] G_LDR = 2'd0;
  localparam logic [1:0] G_C0  = 2'd1;
  localparam logic [1:0] G_C1  = 2'd2;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("sdram_port_arbiter: TIMEOUT must be at least 1");
  end

  state_t        state, state_nxt;
  logic [1:0]    gnt, gnt_nxt;
  logic          rr_last;   // last read client granted; the other one wins a tie
  logic          to_hit;    // watchdog expiry this cycle
  logic          done_go;   // access completes this cycle, ack next cycle
  logic [DW-1:0] rd_val;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] to_cnt;
`endif

  // Next-state and grant decision
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    to_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (ldr_req) begin
          state_nxt = S_ISSUE;
          gnt_nxt   = G_LDR;
        end else if (!ldr_active && (c0_req || c1_req)) begin
          state_nxt = S_ISSUE;
          if (c0_req && c1_req) gnt_nxt = rr_last ? G_C0 : G_C1;
          else                  gnt_nxt = c0_req  ? G_C0 : G_C1;
        end
      end
      // A zero-wait core may ack in the same cycle as the strobe.
      S_ISSUE: state_nxt = mem_ack ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (mem_ack) begin
          state_nxt = S_DONE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          // the count reaches TIMEOUT on this cycle
          state_nxt = S_DONE;
          to_hit    = 1'b1;
        end
`endif
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign done_go = ((state == S_ISSUE) || (state == S_WAIT)) && (state_nxt == S_DONE);
  assign rd_val  = to_hit ? {DW{1'b1}} : mem_dout;

  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Registered command, acks and client data
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      gnt      <= G_LDR;
      rr_last  <= 1'b1;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_rd   <= 1'b0;
      mem_we   <= 1'b0;
      ldr_ack  <= 1'b0;
      c0_ack   <= 1'b0;
      c1_ack   <= 1'b0;
      c0_data  <= '0;
      c1_data  <= '0;
      busy     <= 1'b0;
    end else begin
      mem_rd  <= 1'b0;
      mem_we  <= 1'b0;
      ldr_ack <= 1'b0;
      c0_ack  <= 1'b0;
      c1_ack  <= 1'b0;
      busy    <= (state_nxt != S_IDLE);

      if ((state == S_IDLE) && (state_nxt == S_ISSUE)) begin
        gnt <= gnt_nxt;
        case (gnt_nxt)
          G_LDR: begin
            mem_addr <= ldr_addr;
            mem_din  <= ldr_data;
            mem_we   <= 1'b1;
          end
          G_C0: begin
            mem_addr <= c0_addr;
            mem_rd   <= 1'b1;
            rr_last  <= 1'b0;
          end
          default: begin
            mem_addr <= c1_addr;
            mem_rd   <= 1'b1;
            rr_last  <= 1'b1;
          end
        endcase
      end

      if (done_go) begin
        case (gnt)
          G_LDR: ldr_ack <= 1'b1;
          G_C0: begin
            c0_ack  <= 1'b1;
            c0_data <= rd_val;
          end
          default: begin
            c1_ack  <= 1'b1;
            c1_data <= rd_val;
          end
        endcase
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if ((state == S_IDLE) && (state_nxt == S_ISSUE)) to_cnt <= '0;
      else if (state == S_WAIT)                        to_cnt <= to_cnt + CW'(1);
      if (to_hit) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
